// File: rtl/fifo_pkg.sv
// ============================================================================
// fifo_pkg : shared defaults and read-mode encodings for fifo_param
// Revision : 1.0
// ============================================================================
`default_nettype none

package fifo_pkg;

  localparam int FIFO_WIDTH_DEFAULT    = 8;
  localparam int FIFO_ADDR_BIT_DEFAULT = 4;

  typedef enum logic {
    FIFO_MODE_REG  = 1'b0,
    FIFO_MODE_FWFT = 1'b1
  } fifo_mode_e;

endpackage : fifo_pkg

`default_nettype wire

// File: rtl/fifo_mem.sv
// ============================================================================
// fifo_mem : DEPTH x WIDTH simple dual-port storage, sync write, async read
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH    = FIFO_WIDTH_DEFAULT,
  parameter int ADDR_BIT = FIFO_ADDR_BIT_DEFAULT
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_BIT-1:0] waddr,
  input  logic [WIDTH-1:0]    wdata,
  input  logic [ADDR_BIT-1:0] raddr,
  output logic [WIDTH-1:0]    rdata
);

  localparam int DEPTH = 2 ** ADDR_BIT;

  // Contents are deliberately not reset so the array can map onto RAM.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule : fifo_mem

`default_nettype wire

// File: rtl/fifo_param.sv
// ============================================================================
// fifo_param : parameterised synchronous FIFO, registered or FWFT read
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH    = FIFO_WIDTH_DEFAULT,
  parameter int ADDR_BIT = FIFO_ADDR_BIT_DEFAULT,
  parameter int AF_LEVEL = (2 ** ADDR_BIT) - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                wen,
  input  logic [WIDTH-1:0]    in,
  input  logic                ren,
  output logic [WIDTH-1:0]    out,
  output logic                valid,
  output logic                empty,
  output logic                full,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [ADDR_BIT:0]   count,
  output logic                overflow,
  output logic                underflow
);

  localparam logic [ADDR_BIT:0] FULL_COUNT = {1'b1, {ADDR_BIT{1'b0}}};
  localparam logic [ADDR_BIT:0] PTR_ONE    = {{ADDR_BIT{1'b0}}, 1'b1};
  localparam logic [ADDR_BIT:0] AF_COUNT   = AF_LEVEL[ADDR_BIT:0];
  localparam logic [ADDR_BIT:0] AE_COUNT   = AE_LEVEL[ADDR_BIT:0];

  logic [ADDR_BIT:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BIT:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_BIT:0] count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              wr_accept, rd_accept, mem_we;
  logic [WIDTH-1:0]  mem_rdata;

  assign empty        = (count_q == '0);
  assign full         = (count_q == FULL_COUNT);
  assign almost_full  = (count_q >= AF_COUNT);
  assign almost_empty = (count_q <= AE_COUNT);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign wr_accept = wen && !full;
  assign rd_accept = ren && !empty;
  assign mem_we    = wr_accept && !clr && rst_n;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clr) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_accept) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_accept) rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (wen && full) overflow_d = 1'b1;
      if (ren && empty) underflow_d = 1'b1;
    end
    count_d = wr_ptr_d - rd_ptr_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem #(
    .WIDTH    (WIDTH),
    .ADDR_BIT (ADDR_BIT)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q[ADDR_BIT-1:0]),
    .wdata (in),
    .raddr (rd_ptr_q[ADDR_BIT-1:0]),
    .rdata (mem_rdata)
  );

  generate
    if (FWFT == int'(FIFO_MODE_FWFT)) begin : g_fwft
      // Head word is driven straight from the async read port; zero while empty.
      assign valid = !empty;
      assign out   = empty ? '0 : mem_rdata;
    end else begin : g_reg
      logic [WIDTH-1:0] out_q, out_d;
      logic             valid_q, valid_d;

      always_comb begin
        out_d   = out_q;
        valid_d = 1'b0;
        if (!clr && rd_accept) begin
          out_d   = mem_rdata;
          valid_d = 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          out_q   <= '0;
          valid_q <= 1'b0;
        end else begin
          out_q   <= out_d;
          valid_q <= valid_d;
        end
      end

      assign out   = out_q;
      assign valid = valid_q;
    end
  endgenerate

endmodule : fifo_param

`default_nettype wire

// File: doc/fifo_param.md
FIFO_PARAM -- requirements
Module: fifo_param

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter ADDR_BIT, default 4, log2 of depth; DEPTH = 2**ADDR_BIT.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2, almost_full threshold in words.
REQ-004 SHALL have parameter AE_LEVEL, default 2, almost_empty threshold in words.
REQ-005 SHALL have parameter FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-006 SHALL have ports, in order: clk in 1, rising-edge clock; rst_n in 1, reset.
REQ-007 Reset SHALL be synchronous and active-low; the block SHALL use one clock, clk.
REQ-008 SHALL have ports: clr in 1, synchronous flush; wen in 1, write request; in in WIDTH, write data; ren in 1, read request.
REQ-009 SHALL have ports: out out WIDTH, read data; valid out 1, out qualifier; empty, full, almost_full, almost_empty out 1 each, status.
REQ-010 SHALL have ports: count out ADDR_BIT+1, stored word count; overflow out 1 and underflow out 1, sticky error flags.

Function
REQ-011 Write SHALL be accepted iff wen=1 and full=0; the word is stored at the write pointer and the pointer increments.
REQ-012 Read SHALL be accepted iff ren=1 and empty=0; the read pointer increments.
REQ-013 Pointers SHALL be ADDR_BIT+1 bits binary, wrapping modulo 2*DEPTH; the address is the low ADDR_BIT bits.
REQ-014 count SHALL equal wr_ptr - rd_ptr modulo 2**(ADDR_BIT+1), registered, range 0..DEPTH.
REQ-015 Status SHALL be: empty = (count==0), full = (count==DEPTH), almost_full = (count>=AF_LEVEL), almost_empty = (count<=AE_LEVEL); all decoded from registered state.
REQ-016 Simultaneous accepted read and write SHALL leave count unchanged.
REQ-017 When full, wen=1 with ren=1 SHALL accept only the read; the write SHALL be dropped and overflow SHALL be set.
REQ-018 When empty, ren=1 with wen=1 SHALL accept only the write and SHALL set underflow.
REQ-019 overflow SHALL set on wen=1 while full=1, and underflow SHALL set on ren=1 while empty=1; both SHALL hold until rst_n=0 or clr=1.
REQ-020 FWFT=0: after an accepted read in cycle N, out SHALL present the popped word and valid SHALL be 1 in cycle N+1 only; otherwise out SHALL hold and valid SHALL be 0.
REQ-021 FWFT=1: out SHALL continuously present the head word and valid SHALL equal !empty.
REQ-022 FWFT=1: a word written into an empty FIFO in cycle N SHALL appear on out with valid=1 in cycle N+1.
REQ-023 clr=1 SHALL zero the pointers, count, overflow, underflow and valid in the next cycle, leave memory contents unchanged, and ignore wen/ren that cycle.
REQ-024 Priority SHALL be rst_n > clr > wen/ren.

Reset
REQ-025 With rst_n=0 at a clock edge: pointers=0, count=0, out=0, valid=0, empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0), overflow=0, underflow=0.
REQ-026 Memory contents SHALL NOT be reset.
REQ-027 Reset mid-operation SHALL discard all stored words; the first write after reset SHALL land at address 0.

Structure
REQ-028 A shared package fifo_pkg SHALL hold the default WIDTH/ADDR_BIT constants and the FWFT mode encodings (registered = 0, fwft = 1).
REQ-029 Storage SHALL be a sub-module fifo_mem: DEPTH x WIDTH simple dual-port, synchronous write, asynchronous read.
REQ-030 Pointer, flag and output logic SHALL reside in fifo_param.

Verification (WIDTH=8, ADDR_BIT=4)
REQ-031 Write 1..16 then one extra write -> full=1 at count 16, almost_full=1 from count 14, overflow=1; reading 16 words returns 1..16 and 17 is never read.
REQ-032 FWFT=0, write 5 then read -> out=5 and valid=1 exactly one cycle after ren; valid=0 the following cycle.
REQ-033 FWFT=1, write 0xA5 into an empty FIFO -> out=0xA5, valid=1 the next cycle, with no ren.
REQ-034 Hold 8 words, run 40 cycles of simultaneous wen/ren with incrementing data -> count stays 8, data order is preserved across pointer wrap, and no flags are set.
REQ-035 ren with wen on an empty FIFO -> underflow=1 and count=1; clr -> count=0, underflow=0, empty=1 next cycle.
REQ-036 Assert rst_n=0 with count=10 -> all REQ-025 values next cycle; a subsequent write/read returns the new word.
